// File: rtl/unidade_controle_ir.sv
// Control FSM for the 9-bit multi-cycle processor: fetches into IR in T0, then
// decodes IIIXXXYYY and sequences bus select, register enables and ALU over T1-T3.
module unidade_controle_ir (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       Gnz,
  output logic       IRin,
  output logic [7:0] Rout,
  output logic       Gout,
  output logic       DINout,
  output logic [7:0] Rin,
  output logic       Ain,
  output logic       Gin,
  output logic [1:0] AluOp,
  output logic       Done,
  output logic [1:0] Tstep
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_op;
  logic [7:0] w_x_dec;
  logic [7:0] w_y_dec;
  logic       w_is_alu;
  logic [1:0] w_alu_fn;

  assign w_op     = IR[8:6];
  assign w_x_dec  = 8'b0000_0001 << IR[5:3];
  assign w_y_dec  = 8'b0000_0001 << IR[2:0];
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND);

  always_comb begin
    w_alu_fn = 2'b00;
    case (w_op)
      OP_SUB:  w_alu_fn = 2'b01;
      OP_AND:  w_alu_fn = 2'b10;
      default: w_alu_fn = 2'b00;
    endcase
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) r_state <= T0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    IRin   = 1'b0;
    Rout   = 8'h00;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = 8'h00;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AluOp  = 2'b00;
    Done   = 1'b0;
    Tstep  = r_state;
    case (r_state)
      T0: begin
        IRin   = Run;
        w_next = Run ? T1 : T0;
      end
      T1: begin
        w_next = T0;
        case (w_op)
          OP_MV: begin
            Rout = w_y_dec;
            Rin  = w_x_dec;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_x_dec;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Rout   = w_x_dec;
            Ain    = 1'b1;
            w_next = T2;
          end
          OP_MVNZ: begin
            if (Gnz) begin
              Rout = w_y_dec;
              Rin  = w_x_dec;
            end
            Done = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        w_next = T3;
        if (w_is_alu) begin
          Rout  = w_y_dec;
          Gin   = 1'b1;
          AluOp = w_alu_fn;
        end
      end
      T3: begin
        w_next = T0;
        if (w_is_alu) begin
          Gout = 1'b1;
          Rin  = w_x_dec;
        end
        Done = 1'b1;
      end
      default: w_next = T0;
    endcase
    // Reset forces every output low, including IRin which would otherwise follow Run in T0.
    if (Resetn) begin
      IRin   = 1'b0;
      Rout   = 8'h00;
      Gout   = 1'b0;
      DINout = 1'b0;
      Rin    = 8'h00;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AluOp  = 2'b00;
      Done   = 1'b0;
      Tstep  = 2'd0;
    end
  end

endmodule

// File: tb/tb_unidade_controle_ir.sv
// Directed self-checking bench for unidade_controle_ir: each scenario task drives
// IR/Run/Gnz step by step and compares the packed control outputs against hand values.
module tb_unidade_controle_ir;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       Gnz;
  logic       IRin;
  logic [7:0] Rout;
  logic       Gout;
  logic       DINout;
  logic [7:0] Rin;
  logic       Ain;
  logic       Gin;
  logic [1:0] AluOp;
  logic       Done;
  logic [1:0] Tstep;

  int checks   = 0;
  int failures = 0;

  unidade_controle_ir dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .IR    (IR),
    .Gnz   (Gnz),
    .IRin  (IRin),
    .Rout  (Rout),
    .Gout  (Gout),
    .DINout(DINout),
    .Rin   (Rin),
    .Ain   (Ain),
    .Gin   (Gin),
    .AluOp (AluOp),
    .Done  (Done),
    .Tstep (Tstep)
  );

  always #5 Clock = ~Clock;

  logic [25:0] w_obs;
  assign w_obs = {Tstep, IRin, Rout, Rin, Gout, DINout, Ain, Gin, AluOp, Done};

  // Expected output vector built from hand-computed field values.
  function automatic logic [25:0] pk(input logic [1:0] t, input logic irin,
                                     input logic [7:0] rout, input logic [7:0] rin,
                                     input logic gout, input logic dinout, input logic ain,
                                     input logic gin, input logic [1:0] aluop, input logic done);
    return {t, irin, rout, rin, gout, dinout, ain, gin, aluop, done};
  endfunction

  // Advance to just after the next rising edge so new state is settled.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] e;
    Resetn = 1'b1; Run = 1'b1; IR = 9'b010_001_010; Gnz = 1'b0;
    #2;
    e = '0;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_hold got=%h exp=%h", w_obs, e); end
    tick();
    Resetn = 1'b0; Run = 1'b0;
    #1;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_release got=%h exp=%h", w_obs, e); end
    tick();
    #1;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_idle got=%h exp=%h", w_obs, e); end
    // add R1,R2 then reset mid-T2
    Run = 1'b1; IR = 9'b010_001_010;
    #1;
    e = pk(2'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL add_t0 got=%h exp=%h", w_obs, e); end
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h02, 8'h00, 0, 0, 1, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL add_t1 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd2, 1'b0, 8'h04, 8'h00, 0, 0, 0, 1, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL add_t2 got=%h exp=%h", w_obs, e); end
    Resetn = 1'b1;
    #1;
    e = '0;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_async got=%h exp=%h", w_obs, e); end
    tick();
    Resetn = 1'b0;
    #1;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_restart got=%h exp=%h", w_obs, e); end
    tick(); #1;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL rst_stay_t0 got=%h exp=%h", w_obs, e); end
  endtask

  task automatic test_mvi();
    logic [25:0] e;
    Run = 1'b1; IR = 9'b001_010_000; #1;
    e = pk(2'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mvi_t0 got=%h exp=%h", w_obs, e); end
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h00, 8'h04, 0, 1, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mvi_t1 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = '0;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mvi_after got=%h exp=%h", w_obs, e); end
  endtask

  task automatic test_mv();
    logic [25:0] e;
    Run = 1'b1; IR = 9'b000_001_110; #1;
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h40, 8'h02, 0, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mv_r1_r6 got=%h exp=%h", w_obs, e); end
    tick();
    Run = 1'b1; IR = 9'b000_011_011; #1;
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h08, 8'h08, 0, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mv_r3_r3 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    checks++; if (Tstep !== 2'd0) begin failures++; $display("FAIL mv_after_tstep got=%0d exp=0", Tstep); end
  endtask

  task automatic test_sub();
    logic [25:0] e;
    Run = 1'b1; IR = 9'b011_111_000; #1;
    tick(); Run = 1'b1; #1;
    e = pk(2'd1, 1'b0, 8'h80, 8'h00, 0, 0, 1, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL sub_t1 got=%h exp=%h", w_obs, e); end
    tick(); Run = 1'b0; #1;
    e = pk(2'd2, 1'b0, 8'h01, 8'h00, 0, 0, 0, 1, 2'b01, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL sub_t2 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd3, 1'b0, 8'h00, 8'h80, 1, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL sub_t3 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = '0;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL sub_after got=%h exp=%h", w_obs, e); end
  endtask

  task automatic test_mvnz();
    logic [25:0] e;
    Run = 1'b1; IR = 9'b110_100_101; Gnz = 1'b0; #1;
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mvnz_g0 got=%h exp=%h", w_obs, e); end
    tick();
    Run = 1'b1; Gnz = 1'b1; #1;
    tick(); Run = 1'b0; #1;
    e = pk(2'd1, 1'b0, 8'h20, 8'h10, 0, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL mvnz_g1 got=%h exp=%h", w_obs, e); end
    tick(); Gnz = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    Run = 1'b1; IR = 9'b100_000_001; #1;
    e = pk(2'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c1 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd1, 1'b0, 8'h01, 8'h00, 0, 0, 1, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c2 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd2, 1'b0, 8'h02, 8'h00, 0, 0, 0, 1, 2'b10, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c3 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd3, 1'b0, 8'h00, 8'h01, 1, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c4 got=%h exp=%h", w_obs, e); end
    tick(); IR = 9'b111_000_000; #1;
    e = pk(2'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c5 got=%h exp=%h", w_obs, e); end
    tick(); #1;
    e = pk(2'd1, 1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1);
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c6 got=%h exp=%h", w_obs, e); end
    Run = 1'b0;
    tick(); #1;
    e = '0;
    checks++; if (w_obs !== e) begin failures++; $display("FAIL b2b_c7 got=%h exp=%h", w_obs, e); end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_mv();
    test_sub();
    test_mvnz();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
